bsu_element_load_seq: RTL

- Upstream sequencer for the 7-way element-strobe decoder in the beam steering unit.
- Accepts a burst of 7 phase words over a valid/ready interface and buffers them.
- Then walks the element address map (6, 8, ..., 18), driving the decoder's sel/en inputs and a matching phase bus.
- Guarantees setup and hold margins around each en strobe so the selected phase-shifter latch captures stable data.

---
 rtl/bsu_element_load_seq.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/bsu_element_load_seq.sv
// Upstream sequencer for the beam steering unit's 7-way element-strobe decoder.
// Buffers a burst of phase words, then walks the element address map.
// For each element it drives sel/phase_bus, raises en, and keeps sel/phase_bus
// stable for a setup margin before the strobe and a hold cycle after it.
//
// Handshake: a word transfers on every rising edge where in_valid and
// in_ready are both high. in_ready is high only in LOAD and does not depend
// on in_valid. The sender holds in_data stable while in_valid is high.
module bsu_element_load_seq #(
    parameter int PHASE_W    = 6,
    parameter int N_ELEM     = 7,
    parameter int BASE_ADDR  = 6,
    parameter int ADDR_STEP  = 2,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               in_valid,
    input  logic [PHASE_W-1:0] in_data,
    output logic               in_ready,
    output logic [4:0]         sel,
    output logic               en,
    output logic [PHASE_W-1:0] phase_bus,
    output logic               busy,
    output logic               done,
    output logic [2:0]         dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int TMR_W = 8;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_ELEM - 1);
    localparam logic [TMR_W-1:0] SETUP_LAST  = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] STROBE_LAST = TMR_W'(STROBE_CYC - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;     // words accepted so far in LOAD
    logic [IDX_W-1:0]   idx_q, idx_d;     // element currently addressed
    logic [TMR_W-1:0]   tmr_q, tmr_d;     // cycles spent in SETUP or STROBE
    logic               done_q, done_d;
    logic               wr_en;
    logic               active;
    logic [PHASE_W-1:0] buf_q [N_ELEM];

    // State, counters and done pulse register; reset returns everything to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            tmr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            done_q  <= done_d;
        end
    end

    // Phase word buffer: cleared by reset, written only on accepted LOAD words.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ELEM; i++) begin
                buf_q[i] <= '0;
            end
        end else if (wr_en) begin
            buf_q[cnt_q] <= in_data;
        end
    end

    // Next-state logic; abort overrides every non-idle transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_SETUP;
                        cnt_d   = '0;
                        idx_d   = '0;
                        tmr_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_q == SETUP_LAST) begin
                    state_d = ST_STROBE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_STROBE: begin
                if (tmr_q == STROBE_LAST) begin
                    state_d = ST_HOLD;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_SETUP;
                    idx_d   = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            tmr_d   = '0;
            done_d  = 1'b0;
            wr_en   = 1'b0;
        end
    end

    // sel/phase_bus derive from idx_q, which only moves on the SETUP entry
    // edge, so they are stable across the whole setup/strobe/hold window.
    assign active      = (state_q == ST_SETUP) || (state_q == ST_STROBE) ||
                         (state_q == ST_HOLD);
    assign sel         = active ? 5'(BASE_ADDR + ADDR_STEP * int'(idx_q)) : 5'd0;
    assign phase_bus   = active ? buf_q[idx_q] : '0;
    assign en          = (state_q == ST_STROBE);
    assign in_ready    = (state_q == ST_LOAD);
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule
